// File: rtl/msmv_multi_if.sv
// Control/status bundle for the multi-channel monostable: per-channel triggers,
// shared pulse length and retrigger mode in; pulse, done strobe and busy out.
interface msmv_multi_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 8
);
  logic [CHANNELS-1:0] trigger;
  logic [CNT_W-1:0]    width;
  logic                retrig;
  logic [CHANNELS-1:0] pulse;
  logic [CHANNELS-1:0] done;
  logic [CHANNELS-1:0] busy;

  modport master (
    output trigger, width, retrig,
    input  pulse, done, busy
  );

  modport slave (
    input  trigger, width, retrig,
    output pulse, done, busy
  );
endinterface

// File: rtl/msmv_multi.sv
// Multi-channel monostable pulse generator: each channel fires a programmable-length
// pulse on a trigger rising edge, with optional retrigger, hold-off and end strobe.
module msmv_multi #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned HOLDOFF  = 2
) (
  input logic         clk,
  input logic         rst,
  msmv_multi_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  localparam int unsigned     HOLD_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = (HOLDOFF > 0) ? HOLD_W'(HOLDOFF - 1) : '0;
  localparam bit              HAS_HOLD  = (HOLDOFF != 0);

  // Shared decode of the programmed length; a zero length never starts a pulse.
  logic             width_nz_c;
  logic [CNT_W-1:0] width_m1_c;

  assign width_nz_c = |bus.width;
  assign width_m1_c = bus.width - CNT_W'(1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hcnt_q, hcnt_d;
    logic              trig_q;
    logic              rise_c;
    logic              done_d;
    logic              pulse_q, done_q, busy_q;

    assign rise_c = bus.trigger[i] & ~trig_q;

    // State, counters and registered outputs; outputs follow the next state.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        hcnt_q  <= '0;
        trig_q  <= 1'b0;
        pulse_q <= 1'b0;
        done_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        hcnt_q  <= hcnt_d;
        trig_q  <= bus.trigger[i];
        pulse_q <= (state_d == ACTIVE);
        done_q  <= done_d;
        busy_q  <= (state_d != IDLE);
      end
    end

    // Next-state logic; an accepted retrigger beats expiry in the same cycle.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hcnt_d  = hcnt_q;
      done_d  = 1'b0;
      case (state_q)
        IDLE: begin
          if (rise_c && width_nz_c) begin
            cnt_d   = width_m1_c;
            state_d = ACTIVE;
          end
        end
        ACTIVE: begin
          if (bus.retrig && rise_c && width_nz_c) begin
            cnt_d = width_m1_c;
          end else if (cnt_q == '0) begin
            done_d = 1'b1;
            if (HAS_HOLD) begin
              state_d = HOLD;
              hcnt_d  = HOLD_LOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        HOLD: begin
          if (hcnt_q == '0) begin
            state_d = IDLE;
          end else begin
            hcnt_d = hcnt_q - HOLD_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    assign bus.pulse[i] = pulse_q;
    assign bus.done[i]  = done_q;
    assign bus.busy[i]  = busy_q;
  end

endmodule

// File: tb/tb_msmv_multi.sv
// Directed scenarios for msmv_multi; per-cycle expected {pulse,done,busy} words are
// queued when a scenario is set up and popped/compared as the DUT runs it.
module tb_msmv_multi;
  localparam int unsigned CH   = 4;
  localparam int unsigned CW   = 8;
  localparam int unsigned HO   = 2;
  localparam int          MAXC = 300;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  msmv_multi_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

  msmv_multi #(.CHANNELS(CH), .CNT_W(CW), .HOLDOFF(HO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Per-cycle stimulus and expectation tables for the current scenario.
  logic [CH-1:0] s_trig [MAXC];
  logic [CW-1:0] s_w    [MAXC];
  logic          s_rt   [MAXC];
  logic          s_rst  [MAXC];
  logic [CH-1:0] e_p    [MAXC];
  logic [CH-1:0] e_d    [MAXC];
  logic [CH-1:0] e_b    [MAXC];

  logic [3*CH-1:0] exp_q [$];
  string tag;
  int checks   = 0;
  int failures = 0;

  task automatic clear_scn(input string name, input logic [CW-1:0] w, input logic rt);
    tag = name;
    for (int c = 0; c < MAXC; c++) begin
      s_trig[c] = '0; s_w[c] = w; s_rt[c] = rt; s_rst[c] = 1'b0;
      e_p[c] = '0; e_d[c] = '0; e_b[c] = '0;
    end
  endtask

  task automatic trig_hi(input int ch, input int a, input int b);
    for (int c = a; c <= b; c++) s_trig[c][ch] = 1'b1;
  endtask

  task automatic set_w(input int from, input logic [CW-1:0] w);
    for (int c = from; c < MAXC; c++) s_w[c] = w;
  endtask

  // Expected waveform of one channel: pulse a..b, done at b+1 (if strobe), busy a..b+hold.
  task automatic exp_shot(input int ch, input int a, input int b, input bit strobe, input int hold);
    for (int c = a; c <= b; c++) e_p[c][ch] = 1'b1;
    for (int c = a; c <= b + hold; c++) e_b[c][ch] = 1'b1;
    if (strobe) e_d[b+1][ch] = 1'b1;
  endtask

  task automatic run(input int n);
    logic [3*CH-1:0] exp_v, obs_v;
    for (int c = 0; c < n; c++) exp_q.push_back({e_p[c], e_d[c], e_b[c]});
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      obs_v = {bus.pulse, bus.done, bus.busy};
      checks++;
      assert (obs_v === exp_v) else begin
        failures++;
        $error("FAIL %s cycle=%0d pulse/done/busy observed=%h expected=%h", tag, c, obs_v, exp_v);
      end
      rst          = s_rst[c];
      bus.trigger  = s_trig[c];
      bus.width    = s_w[c];
      bus.retrig   = s_rt[c];
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.trigger = '0;
    bus.width   = '0;
    bus.retrig  = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state: all outputs low while and after reset is applied.
    clear_scn("reset", 8'd10, 1'b0);
    s_rst[0] = 1'b1; s_rst[1] = 1'b1;
    run(5);

    // Basic shot on ch0; width change mid-pulse must not matter.
    clear_scn("basic", 8'd10, 1'b0);
    trig_hi(0, 5, 8);
    set_w(8, 8'd3);
    exp_shot(0, 6, 15, 1'b1, HO);
    run(22);

    // Non-retriggerable: edges at 10 (ACTIVE) and 16 (HOLD) ignored, 18 fires.
    clear_scn("nonretrig", 8'd10, 1'b0);
    trig_hi(1, 5, 6); trig_hi(1, 10, 11); trig_hi(1, 16, 16); trig_hi(1, 18, 19);
    exp_shot(1, 6, 15, 1'b1, HO);
    exp_shot(1, 19, 28, 1'b1, HO);
    run(34);

    // Retriggerable: second edge mid-pulse extends without a gap.
    clear_scn("retrig_mid", 8'd10, 1'b1);
    trig_hi(2, 5, 6); trig_hi(2, 12, 13);
    exp_shot(2, 6, 22, 1'b1, HO);
    run(28);

    // Retrigger on the expiry cycle wins: no done at 16.
    clear_scn("retrig_expiry", 8'd10, 1'b1);
    trig_hi(2, 5, 6); trig_hi(2, 15, 15);
    exp_shot(2, 6, 25, 1'b1, HO);
    run(30);

    // Zero width: edge ignored entirely.
    clear_scn("width_zero", 8'd0, 1'b0);
    trig_hi(0, 3, 4);
    run(8);

    // Maximum width: exactly 255 cycles.
    clear_scn("width_max", 8'd255, 1'b0);
    trig_hi(3, 2, 3);
    exp_shot(3, 3, 257, 1'b1, HO);
    run(262);

    // Reset mid-pulse kills ch0 without done; ch1 high across release fires after it.
    clear_scn("reset_mid", 8'd20, 1'b0);
    trig_hi(0, 5, 6);
    trig_hi(1, 10, 14);
    s_rst[10] = 1'b1; s_rst[11] = 1'b1;
    exp_shot(0, 6, 10, 1'b0, 0);
    exp_shot(1, 13, 32, 1'b1, HO);
    run(38);

    // All channels together, then ch3 retriggered.
    clear_scn("concurrent", 8'd7, 1'b1);
    for (int ch = 0; ch < CH; ch++) trig_hi(ch, 3, 4);
    trig_hi(3, 8, 8);
    for (int ch = 0; ch < 3; ch++) exp_shot(ch, 4, 10, 1'b1, HO);
    exp_shot(3, 4, 15, 1'b1, HO);
    run(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msmv_multi.md
# msmv_multi

Multi-channel, parametrised monostable pulse generator: the successor to the single-channel fixed-width one-shot. Each of `CHANNELS` independent channels detects a rising edge on its trigger and emits a pulse of run-time-programmable length. The pulse can be retriggerable or non-retriggerable, is followed by an optional hold-off window, and produces an end-of-pulse strobe. It sits between debounced control inputs and downstream logic that needs fixed-duration enables or strobes.

## Interface
- `CHANNELS`, 4, number of independent one-shot channels
- `CNT_W`, 8, width of the pulse-length input and per-channel counter (max pulse 2^CNT_W−1 cycles)
- `HOLDOFF`, 2, cycles after each pulse during which triggers are ignored (0 = none)

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `trigger`  in  CHANNELS  per-channel trigger level; rising edge fires
- `width`  in  CNT_W  shared pulse length in cycles, sampled only when an edge is accepted
- `retrig`  in  1  mode: 1 = retriggerable, 0 = non-retriggerable (sampled each cycle)
- `pulse`  out  CHANNELS  registered one-shot outputs
- `done`  out  CHANNELS  registered 1-cycle strobe at pulse end
- `busy`  out  CHANNELS  channel in ACTIVE or HOLD

## Operation
- Per channel: `trig_q` register, edge = `trigger & ~trig_q`, `CNT_W`-bit down-counter, FSM IDLE / ACTIVE / HOLD. Channels fully independent.
- IDLE: edge with `width`≠0 → load cnt = width−1, go ACTIVE. Edge with `width`=0 → ignored, no pulse, no done.
- ACTIVE (`pulse`=1):
  - retrig=1 and edge and width≠0 → reload cnt = width−1, stay ACTIVE. This wins over expiry in the same cycle: no gap, no done.
  - otherwise cnt=0 → exit to HOLD (HOLDOFF>0) or IDLE (HOLDOFF=0), `done` pulses.
  - otherwise cnt decrements.
  - retrig=0: edges in ACTIVE ignored.
- HOLD: hold-off counter runs `HOLDOFF` cycles, then IDLE. Edges ignored in both modes, including on the last HOLD cycle. A trigger held high across HOLD does not fire on HOLD exit; a new rising edge is required.
- `busy` = state≠IDLE. `pulse` = state==ACTIVE (registered).
- `width` change during ACTIVE has no effect unless a retrigger is accepted.
- Reset: state IDLE, cnt 0, hold counter 0, trig_q 0. `pulse`, `done`, `busy` = 0 on the cycle after `rst` is sampled high. Reset mid-pulse kills the pulse with no `done`. `trigger` high when reset is released counts as an edge, because trig_q=0.

## Timing
- Edge sampled at clock k → `pulse`/`busy` high on cycles k+1 … k+W (exactly W cycles).
- `done` high on cycle k+W+1 only, the first cycle with `pulse` low.
- `busy` high k+1 … k+W+HOLDOFF. Earliest accepted next edge is sampled at k+W+HOLDOFF+1, giving a pulse at k+W+HOLDOFF+2.
- HOLDOFF=0: minimum one low cycle between back-to-back pulses.
- Retrigger sampled at cycle j in ACTIVE → `pulse` stays high through cycle j+W', where W' = current `width`.
- Latency trigger→pulse: 1 cycle. No combinational path from input to output.

## Test plan
- Basic: CHANNELS=4, width=10, HOLDOFF=2, retrig=0; ch0 trigger rises at cycle 5 → pulse[0] high cycles 6–15, done[0] at 16, busy[0] 6–17, other channels stay 0.
- Non-retrig and hold-off: width=10, retrig=0; ch1 edges at 5, 10, 16 → single pulse 6–15, edges at 10 and 16 ignored (16 is in HOLD); edge at 18 → pulse 19–28.
- Retrig: width=10, retrig=1; ch2 edges at 5 and 12 → pulse 6–22 continuous, one done at 23. Edge exactly on the expiry cycle (sampled at 15) → pulse 6–25, no done at 16.
- Zero/max width: width=0 edge → no pulse, no done, busy stays 0. width=255 → pulse exactly 255 cycles.
- Reset mid-pulse: width=20, edge at 5, rst high at cycle 10 → pulse low from 11, no done. trigger held high through reset release → pulse begins 1 cycle after release.
- Concurrency: all 4 channels triggered on the same cycle with width=7, then ch3 retriggered → ch0–2 end together, ch3 extended, per-channel done timing correct.
